// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the two-master RAM port-B arbiter: write-strobe encodings
// and the arbitration state type.
package ram_port_arbiter_pkg;

  localparam logic [3:0] WE_READ = 4'b0000;
  localparam logic [3:0] WE_BYTE = 4'b0001;
  localparam logic [3:0] WE_HALF = 4'b0011;
  localparam logic [3:0] WE_WORD = 4'b1111;

  typedef enum logic [0:0] {
    StPrio0,
    StForce1
  } arb_state_t;

endpackage

// File: rtl/ram_port_arbiter_strobe_check.sv
// Combinational legality decode of a byte-enable write strobe.
module ram_port_arbiter_strobe_check
  import ram_port_arbiter_pkg::*;
(
  input  logic [3:0] we_i,
  output logic       legal_o
);

  always_comb begin
    legal_o = 1'b0;
    case (we_i)
      WE_READ, WE_BYTE, WE_HALF, WE_WORD: legal_o = 1'b1;
      default:                            legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates RAM port B between the core LSU (m0, normally preferred) and the
// loader/debug master (m1), which is forced through after STARVE_LIMIT waiting cycles.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_i,

  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  input  logic [3:0]  m0_we_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,

  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic [3:0]  m1_we_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,

  output logic [31:0] addrb_o,
  output logic        enb_o,
  output logic [3:0]  web_o,
  output logic [31:0] dinb_o,
  input  logic [31:0] doutb_i
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  arb_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic        gnt0, gnt1;
  logic [3:0]  sel_we;
  logic        legal;

  logic        rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic        err0_q, err0_d, err1_q, err1_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  // Grants are suppressed while reset is high so nothing reaches the RAM.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        StForce1: begin
          gnt1 = m1_req_i;
          gnt0 = m0_req_i & ~m1_req_i;
        end
        default: begin
          gnt0 = m0_req_i;
          gnt1 = m1_req_i & ~m0_req_i;
        end
      endcase
    end
  end

  // The forced slot lasts a single cycle whether or not m1 still wants it.
  always_comb begin
    cnt_d = '0;
    if (m1_req_i && !gnt1) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
    end
    state_d = StPrio0;
    if (state_q == StPrio0 && cnt_d == CntMax) begin
      state_d = StForce1;
    end
  end

  always_comb begin
    addrb_o = '0;
    dinb_o  = '0;
    enb_o   = 1'b0;
    sel_we  = WE_READ;
    if (gnt0) begin
      addrb_o = m0_addr_i;
      dinb_o  = m0_wdata_i;
      sel_we  = m0_we_i;
      enb_o   = 1'b1;
    end else if (gnt1) begin
      addrb_o = m1_addr_i;
      dinb_o  = m1_wdata_i;
      sel_we  = m1_we_i;
      enb_o   = 1'b1;
    end
  end

  ram_port_arbiter_strobe_check u_strobe_check (
    .we_i    (sel_we),
    .legal_o (legal)
  );

  // Illegal strobes still get a response, but never write.
  assign web_o = legal ? sel_we : WE_READ;

  always_comb begin
    rvalid0_d = gnt0;
    rvalid1_d = gnt1;
    err0_d    = gnt0 & ~legal;
    err1_d    = gnt1 & ~legal;
    rdata0_d  = gnt0 ? doutb_i : rdata0_q;
    rdata1_d  = gnt1 ? doutb_i : rdata1_q;
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StPrio0;
      cnt_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign m0_gnt_o    = gnt0;
  assign m1_gnt_o    = gnt1;
  assign m0_rvalid_o = rvalid0_q;
  assign m1_rvalid_o = rvalid1_q;
  assign m0_err_o    = err0_q;
  assign m1_err_o    = err1_q;
  assign m0_rdata_o  = rdata0_q;
  assign m1_rdata_o  = rdata1_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: directed scenarios plus random traffic against
// a queue/array reference model and a behavioural RAM on port B.
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  localparam int unsigned Limit = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic [3:0]  m0_we = '0, m1_we = '0;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] addrb, dinb, doutb;
  logic        enb;
  logic [3:0]  web;

  always #5 clk = ~clk;

  ram_port_arbiter #(.STARVE_LIMIT(Limit)) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .m0_req_i    (m0_req),
    .m0_addr_i   (m0_addr),
    .m0_we_i     (m0_we),
    .m0_wdata_i  (m0_wdata),
    .m0_gnt_o    (m0_gnt),
    .m0_rvalid_o (m0_rvalid),
    .m0_rdata_o  (m0_rdata),
    .m0_err_o    (m0_err),
    .m1_req_i    (m1_req),
    .m1_addr_i   (m1_addr),
    .m1_we_i     (m1_we),
    .m1_wdata_i  (m1_wdata),
    .m1_gnt_o    (m1_gnt),
    .m1_rvalid_o (m1_rvalid),
    .m1_rdata_o  (m1_rdata),
    .m1_err_o    (m1_err),
    .addrb_o     (addrb),
    .enb_o       (enb),
    .web_o       (web),
    .dinb_o      (dinb),
    .doutb_i     (doutb)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'h1357_9BDF ^ (32'(i) * 32'h0101_0101);
  endfunction

  // Behavioural RAM on port B: combinational read, byte-enabled write at the clock edge.
  logic [31:0] mem [64];
  logic        mem_init = 1'b1;
  assign doutb = mem[addrb[7:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (enb) begin
      for (int b = 0; b < 4; b++) begin
        if (web[b]) mem[addrb[7:2]][8*b +: 8] <= dinb[8*b +: 8];
      end
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  int          errors = 0;
  int          checks = 0;
  rsp_t        q [2][$];
  logic [31:0] ref_mem [64];
  logic [31:0] last_rdata [2];
  int          wait_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic legal_we(input logic [3:0] we);
    return we == 4'b0000 || we == 4'b0001 || we == 4'b0011 || we == 4'b1111;
  endfunction

  // One arbitration cycle: drive both masters, predict the grant and RAM-side signals,
  // and queue the response the granted master must see next cycle.
  task automatic do_cycle(input logic r0, input logic [31:0] a0, input logic [3:0] w0,
                          input logic [31:0] d0, input logic r1, input logic [31:0] a1,
                          input logic [3:0] w1, input logic [31:0] d1);
    logic        g0, g1, ok;
    logic [31:0] ea, ed;
    logic [3:0]  ew;
    logic [5:0]  idx;
    rsp_t        r;
    @(posedge clk);
    #2;
    m0_req = r0; m0_addr = a0; m0_we = w0; m0_wdata = d0;
    m1_req = r1; m1_addr = a1; m1_we = w1; m1_wdata = d1;
    #1;
    if (wait_cnt >= int'(Limit)) begin
      g1 = r1;
      g0 = r0 & ~r1;
    end else begin
      g0 = r0;
      g1 = r1 & ~r0;
    end
    wait_cnt = (r1 && !g1) ? wait_cnt + 1 : 0;
    chk("gnt0", 32'(m0_gnt), 32'(g0));
    chk("gnt1", 32'(m1_gnt), 32'(g1));
    if (g0 || g1) begin
      ea  = g0 ? a0 : a1;
      ed  = g0 ? d0 : d1;
      ew  = g0 ? w0 : w1;
      idx = ea[7:2];
      ok  = legal_we(ew);
      chk("enb", 32'(enb), 32'd1);
      chk("addrb", addrb, ea);
      chk("dinb", dinb, ed);
      chk("web", 32'(web), ok ? 32'(ew) : 32'd0);
      r.rdata = ref_mem[idx];
      r.err   = ~ok;
      q[g0 ? 0 : 1].push_back(r);
      if (ok) begin
        for (int b = 0; b < 4; b++) begin
          if (ew[b]) ref_mem[idx][8*b +: 8] = ed[8*b +: 8];
        end
      end
    end else begin
      chk("enb_idle", 32'(enb), 32'd0);
      chk("web_idle", 32'(web), 32'd0);
      chk("addrb_idle", addrb, 32'd0);
      chk("dinb_idle", dinb, 32'd0);
    end
  endtask

  task automatic idle();
    do_cycle(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  // Grant an m0 access, then assert reset one cycle later: response dropped, write kept.
  task automatic reset_after_grant(input logic [3:0] we);
    do_cycle(1'b1, 32'h20, we, 32'hCAFE_F00D, 1'b0, '0, '0, '0);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    q[0].delete();
    q[1].delete();
    wait_cnt = 0;
    m1_req = 1'b0;
    m0_req = 1'b1;
    #1;
    chk("rst_enb", 32'(enb), 32'd0);
    chk("rst_gnt0", 32'(m0_gnt), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(StPrio0));
    chk("rst_cnt", 32'(dut.cnt_q), 32'd0);
    m0_req = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic mon_port(input int p, input logic rv, input logic [31:0] rd, input logic er);
    rsp_t e;
    if (rv) begin
      if (q[p].size() == 0) begin
        chk($sformatf("rvalid%0d_unexpected", p), 32'(rv), 32'd0);
      end else begin
        e = q[p].pop_front();
        chk($sformatf("rdata%0d", p), rd, e.rdata);
        chk($sformatf("err%0d", p), 32'(er), 32'(e.err));
        last_rdata[p] = e.rdata;
      end
    end else begin
      if (q[p].size() != 0) begin
        void'(q[p].pop_front());
        chk($sformatf("rvalid%0d_missing", p), 32'(rv), 32'd1);
      end
      chk($sformatf("err%0d_idle", p), 32'(er), 32'd0);
      chk($sformatf("rdata%0d_hold", p), rd, last_rdata[p]);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rst_i) begin
        last_rdata[0] = '0;
        last_rdata[1] = '0;
        chk("rst_rvalid0", 32'(m0_rvalid), 32'd0);
        chk("rst_rvalid1", 32'(m1_rvalid), 32'd0);
        chk("rst_rdata0", m0_rdata, 32'd0);
        chk("rst_rdata1", m1_rdata, 32'd0);
      end else begin
        mon_port(0, m0_rvalid, m0_rdata, m0_err);
        mon_port(1, m1_rvalid, m1_rdata, m1_err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  function automatic logic [3:0] rand_we();
    case ($urandom_range(0, 4))
      0:       return 4'b0000;
      1:       return 4'b0001;
      2:       return 4'b0011;
      3:       return 4'b1111;
      default: return 4'($urandom);
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_enb_init", 32'(enb), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    mem_init = 1'b0;

    // Single m0 read of word 0.
    do_cycle(1'b1, 32'h0, 4'b0000, '0, 1'b0, '0, '0, '0);
    idle();

    // Both masters requesting continuously: four m0 grants, then one m1 grant.
    for (int i = 0; i < 10; i++) begin
      do_cycle(1'b1, 32'(i * 4), 4'b0000, '0, 1'b1, 32'(64 + i * 4), 4'b0000, '0);
      chk("starve_pattern", 32'(m1_gnt), 32'((i % 5) == 4));
    end
    idle();

    // m1 word write then read-back.
    do_cycle(1'b0, '0, '0, '0, 1'b1, 32'h18, 4'b1111, 32'hDEAD_BEEF);
    do_cycle(1'b0, '0, '0, '0, 1'b1, 32'h18, 4'b0000, '0);
    idle();

    // Illegal strobe: error response, RAM untouched (checked by the read that follows).
    do_cycle(1'b1, 32'h4, 4'b0101, 32'hFFFF_FFFF, 1'b0, '0, '0, '0);
    do_cycle(1'b1, 32'h4, 4'b0000, '0, 1'b0, '0, '0, '0);
    idle();

    // Reset right after a granted read, and after a granted write.
    reset_after_grant(4'b0000);
    reset_after_grant(4'b1111);
    do_cycle(1'b1, 32'h20, 4'b0000, '0, 1'b0, '0, '0, '0);
    idle();

    // m1 waits three cycles, drops its request, and must wait four more.
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 32'h8, '0, '0, 1'b1, 32'hC, '0, '0);
    do_cycle(1'b1, 32'h8, '0, '0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b1, 32'h8, '0, '0, 1'b1, 32'hC, '0, '0);
      chk("no_early_force", 32'(m1_gnt), 32'd0);
    end
    do_cycle(1'b1, 32'h8, '0, '0, 1'b1, 32'hC, '0, '0);
    chk("force_after_restart", 32'(m1_gnt), 32'd1);

    for (int i = 0; i < 400; i++) begin
      do_cycle(1'($urandom_range(0, 9) < 7), {24'h0, 6'($urandom), 2'b00}, rand_we(), $urandom,
               1'($urandom_range(0, 9) < 6), {24'h0, 6'($urandom), 2'b00}, rand_we(), $urandom);
    end
    idle();
    idle();
    chk("drain", 32'(q[0].size() + q[1].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
